ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage; consumes the ID/EX pipeline register outputs and produces the EX/MEM pipeline register.
- Contains operand forwarding, a single-cycle ALU, and an iterative radix-2 multiply/divide unit.
- Raises a stall so the ID/EX register and earlier stages hold while a multi-cycle op runs.

Parameters:
XLEN, 32, datapath width
MD_ITER, 32, multiply/divide iteration count (equals XLEN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
Ex_In_Rs1 / Ex_In_Rs2  in  5  source register indices
Ex_In_Read_Data_1 / Ex_In_Read_Data_2  in  32  register file operands
Ex_In_Sign_Ex  in  32  sign-extended immediate
Ex_In_acl  in  4  ALU/muldiv op code
Ex_In_Read_Data_2_Sel  in  2  operand-B select
Ex_In_Output_Select  in  2  writeback source, passed through
Ex_In_writereg  in  5  destination register
Ex_In_Reg_Write / Ex_In_MemWrite / Ex_In_MemRead  in  1  control, passed through
Ex_In_opcode  in  7  passed through
Wb_Reg_Write  in  1  MEM/WB write enable (forwarding)
Wb_writereg  in  5  MEM/WB destination (forwarding)
Wb_Data  in  32  MEM/WB writeback value (forwarding)
Ex_Flush  in  1  synchronous bubble/abort
Ex_Stall  out  1  combinational; upstream holds when high
Ex_Mem_Alu_Result  out  32  ALU or muldiv result
Ex_Mem_Store_Data  out  32  forwarded rs2 value
Ex_Mem_writereg  out  5  registered destination
Ex_Mem_Reg_Write / Ex_Mem_MemWrite / Ex_Mem_MemRead  out  1  registered control
Ex_Mem_Output_Select  out  2  registered
Ex_Mem_opcode  out  7  registered

Behaviour:
- Reset: asynchronous, active-high. Clock and reset ports are clk and reset (as named in Ports).
  - All Ex_Mem_* outputs clear to 0.
  - FSM goes to IDLE, iteration counter to 0, Ex_Stall to 0.
- Forwarding, per operand, in priority order:
  1. EX/MEM: selected if Ex_Mem_Reg_Write=1, Ex_Mem_MemRead=0, Ex_Mem_writereg!=0 and writereg==rs.
  2. MEM/WB: selected if Wb_Reg_Write=1, Wb_writereg!=0 and Wb_writereg==rs.
  3. Otherwise the register-file operand.
  - Index 0 is never forwarded. Load-use hazards are the upstream hazard unit's job.
- Operand B select: 00 forwarded rs2; 01 Sign_Ex; 10 constant 4; 11 treated as 00.
- acl codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is B[4:0].
  - 1000 SLT, 1001 SLTU; result is 0 or 1.
  - 1010, 1011: result 0.
  - 1100 MUL (low 32 bits), 1101 MULHU (high 32 bits, unsigned), 1110 DIVU, 1111 REMU.
- ALU ops: result registered into EX/MEM at the next edge; 1-cycle latency; Ex_Stall=0.
- Muldiv FSM:
  - IDLE: if acl[3:2]==11 and Ex_Flush=0, Ex_Stall=1. Operands are latched at the edge, counter is set to 0, and the FSM moves to BUSY. EX/MEM captures a bubble (Reg_Write, MemWrite, MemRead all 0).
  - BUSY: Ex_Stall=1. Perform one shift-add (multiply) or restoring-subtract (divide) step per cycle. EX/MEM captures a bubble each cycle. Move to DONE when counter == MD_ITER-1.
  - DONE: Ex_Stall=0. EX/MEM captures the result with the held instruction's control. Upstream advances on the same edge. FSM returns to IDLE.
  - Total EX occupancy for one muldiv op: MD_ITER+2 cycles.
  - Forwarding sources changing after issue have no effect; operands are latched.
- Divide by zero:
  - DIVU returns 0xFFFFFFFF.
  - REMU returns the dividend.
  - No exception is raised.
- Ex_Flush=1 at an edge, in any state:
  - EX/MEM captures a bubble.
  - FSM is forced to IDLE; any in-flight muldiv is discarded.
  - Ex_Stall is 0 in that cycle.
- Reset asserted mid-operation aborts the muldiv immediately; no partial result is ever written.
- Bubbles still propagate writereg, opcode and Output_Select. All write enables are 0.

Decomposition:
- Package riscv_ex_pkg holds:
  - acl op-code constants;
  - operand-B select codes;
  - FSM state enum (IDLE, BUSY, DONE);
  - XLEN default.
- One sub-module, muldiv_iter, containing the iterative unit: start/busy/done handshake, operands in, 32-bit result out.
- ex_stage keeps forwarding, ALU, FSM glue and the EX/MEM register.

Test Plan:
- Reset: assert reset mid-cycle -> all Ex_Mem_* read 0 immediately (asynchronous), Ex_Stall=0.
- ADD with EX/MEM forwarding: previous op writes x5=7; now x5+x5 with Read_Data_1=0 -> Ex_Mem_Alu_Result=14 after 1 cycle. Repeat with writereg=0 -> no forwarding, result from register file.
- Forwarding priority: EX/MEM and MEM/WB both target x3 (values 9 and 2) -> EX/MEM value 9 is used.
- MUL 0xFFFF×0x10001 -> Ex_Stall high for 33 cycles, result 0xFFFFFFFF, Reg_Write=1 on the DONE edge, bubbles before it. MULHU same operands -> 0.
- DIVU 100/7 -> 14; REMU -> 2. DIVU x/0 -> 0xFFFFFFFF; REMU x/0 -> x.
- Ex_Flush asserted 10 cycles into a DIVU -> Ex_Stall drops, bubble written, FSM IDLE; the next ADD completes in 1 cycle.

Source files
------------

// File: rtl/riscv_ex_pkg.sv
// Shared op codes, operand-B select codes and muldiv FSM states for the execute stage.
package riscv_ex_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [3:0] ACL_ADD   = 4'b0000;
  localparam logic [3:0] ACL_SUB   = 4'b0001;
  localparam logic [3:0] ACL_AND   = 4'b0010;
  localparam logic [3:0] ACL_OR    = 4'b0011;
  localparam logic [3:0] ACL_XOR   = 4'b0100;
  localparam logic [3:0] ACL_SLL   = 4'b0101;
  localparam logic [3:0] ACL_SRL   = 4'b0110;
  localparam logic [3:0] ACL_SRA   = 4'b0111;
  localparam logic [3:0] ACL_SLT   = 4'b1000;
  localparam logic [3:0] ACL_SLTU  = 4'b1001;
  localparam logic [3:0] ACL_RSVD0 = 4'b1010;
  localparam logic [3:0] ACL_RSVD1 = 4'b1011;
  localparam logic [3:0] ACL_MUL   = 4'b1100;
  localparam logic [3:0] ACL_MULHU = 4'b1101;
  localparam logic [3:0] ACL_DIVU  = 4'b1110;
  localparam logic [3:0] ACL_REMU  = 4'b1111;

  localparam logic [1:0] OPB_RS2  = 2'b00;
  localparam logic [1:0] OPB_IMM  = 2'b01;
  localparam logic [1:0] OPB_FOUR = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_e;

endpackage

// File: rtl/ex_stage_muldiv_iter.sv
// Iterative radix-2 multiply/divide unit: one shift-add or restoring-subtract step per cycle.
module muldiv_iter
  import riscv_ex_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int MD_ITER = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            idle_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(MD_ITER);
  localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

  mdState_e        state_q;
  logic [CW-1:0]   count_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [XLEN:0]   mulSum, remShift, remDiff;

  // hi/lo hold {product high, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    remShift = {hi_q, lo_q[XLEN-1]};
    remDiff  = remShift - {1'b0, opnd_q};
    if (!op_q[1]) begin
      hi_d = mulSum[XLEN:1];
      lo_d = {mulSum[0], lo_q[XLEN-1:1]};
    end else if (!remDiff[XLEN]) begin
      hi_d = remDiff[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_d = remShift[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= BUSY;
            count_q <= '0;
            op_q    <= op_i;
            hi_q    <= '0;
            lo_q    <= a_i;
            opnd_q  <= b_i;
          end
        end
        BUSY: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
  assign idle_o   = (state_q == IDLE);
  assign busy_o   = (state_q == BUSY);
  assign done_o   = (state_q == DONE);
  assign result_o = op_q[0] ? hi_q : lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative muldiv glue and the EX/MEM register.
module ex_stage
  import riscv_ex_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int MD_ITER = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      Ex_In_Rs1,
  input  logic [4:0]      Ex_In_Rs2,
  input  logic [XLEN-1:0] Ex_In_Read_Data_1,
  input  logic [XLEN-1:0] Ex_In_Read_Data_2,
  input  logic [XLEN-1:0] Ex_In_Sign_Ex,
  input  logic [3:0]      Ex_In_acl,
  input  logic [1:0]      Ex_In_Read_Data_2_Sel,
  input  logic [1:0]      Ex_In_Output_Select,
  input  logic [4:0]      Ex_In_writereg,
  input  logic            Ex_In_Reg_Write,
  input  logic            Ex_In_MemWrite,
  input  logic            Ex_In_MemRead,
  input  logic [6:0]      Ex_In_opcode,
  input  logic            Wb_Reg_Write,
  input  logic [4:0]      Wb_writereg,
  input  logic [XLEN-1:0] Wb_Data,
  input  logic            Ex_Flush,
  output logic            Ex_Stall,
  output logic [XLEN-1:0] Ex_Mem_Alu_Result,
  output logic [XLEN-1:0] Ex_Mem_Store_Data,
  output logic [4:0]      Ex_Mem_writereg,
  output logic            Ex_Mem_Reg_Write,
  output logic            Ex_Mem_MemWrite,
  output logic            Ex_Mem_MemRead,
  output logic [1:0]      Ex_Mem_Output_Select,
  output logic [6:0]      Ex_Mem_opcode
);

  logic [XLEN-1:0] result_q, storeData_q, result_d;
  logic [4:0]      writereg_q;
  logic            regWrite_q, memWrite_q, memRead_q;
  logic [1:0]      outSel_q;
  logic [6:0]      opcode_q;

  logic [XLEN-1:0] fwdA, fwdB, opB, aluResult, mdResult;
  logic [4:0]      shamt;
  logic            exMemFwd, wbFwd, isMd, mdIdle, mdBusy, mdDone, bubble;

  // EX/MEM beats MEM/WB; a load in EX/MEM has no data yet, so it is never a source.
  always_comb begin
    exMemFwd = regWrite_q && !memRead_q && (writereg_q != 5'd0);
    wbFwd    = Wb_Reg_Write && (Wb_writereg != 5'd0);
    fwdA     = Ex_In_Read_Data_1;
    fwdB     = Ex_In_Read_Data_2;
    if (wbFwd && Wb_writereg == Ex_In_Rs1) fwdA = Wb_Data;
    if (wbFwd && Wb_writereg == Ex_In_Rs2) fwdB = Wb_Data;
    if (exMemFwd && writereg_q == Ex_In_Rs1) fwdA = result_q;
    if (exMemFwd && writereg_q == Ex_In_Rs2) fwdB = result_q;
    unique case (Ex_In_Read_Data_2_Sel)
      OPB_RS2:  opB = fwdB;
      OPB_IMM:  opB = Ex_In_Sign_Ex;
      OPB_FOUR: opB = XLEN'(4);
      default:  opB = fwdB;
    endcase
  end

  always_comb begin
    shamt = opB[4:0];
    unique case (Ex_In_acl)
      ACL_ADD:  aluResult = fwdA + opB;
      ACL_SUB:  aluResult = fwdA - opB;
      ACL_AND:  aluResult = fwdA & opB;
      ACL_OR:   aluResult = fwdA | opB;
      ACL_XOR:  aluResult = fwdA ^ opB;
      ACL_SLL:  aluResult = fwdA << shamt;
      ACL_SRL:  aluResult = fwdA >> shamt;
      ACL_SRA:  aluResult = $unsigned($signed(fwdA) >>> shamt);
      ACL_SLT:  aluResult = {{(XLEN-1){1'b0}}, $signed(fwdA) < $signed(opB)};
      ACL_SLTU: aluResult = {{(XLEN-1){1'b0}}, fwdA < opB};
      ACL_RSVD0, ACL_RSVD1, ACL_MUL, ACL_MULHU, ACL_DIVU, ACL_REMU: aluResult = '0;
      default:  aluResult = '0;
    endcase
  end

  assign isMd = (Ex_In_acl[3:2] == 2'b11);

  muldiv_iter #(.XLEN(XLEN), .MD_ITER(MD_ITER)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (isMd && !Ex_Flush),
    .flush_i  (Ex_Flush),
    .op_i     (Ex_In_acl[1:0]),
    .a_i      (fwdA),
    .b_i      (opB),
    .idle_o   (mdIdle),
    .busy_o   (mdBusy),
    .done_o   (mdDone),
    .result_o (mdResult)
  );

  // The held instruction's own control is written only on the DONE cycle; earlier cycles are bubbles.
  assign Ex_Stall = !reset && !Ex_Flush && ((isMd && mdIdle) || mdBusy);
  assign bubble   = Ex_Flush || Ex_Stall;
  assign result_d = mdDone ? mdResult : aluResult;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      storeData_q <= '0;
      writereg_q  <= '0;
      regWrite_q  <= 1'b0;
      memWrite_q  <= 1'b0;
      memRead_q   <= 1'b0;
      outSel_q    <= '0;
      opcode_q    <= '0;
    end else begin
      result_q    <= result_d;
      storeData_q <= fwdB;
      writereg_q  <= Ex_In_writereg;
      regWrite_q  <= Ex_In_Reg_Write && !bubble;
      memWrite_q  <= Ex_In_MemWrite && !bubble;
      memRead_q   <= Ex_In_MemRead && !bubble;
      outSel_q    <= Ex_In_Output_Select;
      opcode_q    <= Ex_In_opcode;
    end
  end

  assign Ex_Mem_Alu_Result    = result_q;
  assign Ex_Mem_Store_Data    = storeData_q;
  assign Ex_Mem_writereg      = writereg_q;
  assign Ex_Mem_Reg_Write     = regWrite_q;
  assign Ex_Mem_MemWrite      = memWrite_q;
  assign Ex_Mem_MemRead       = memRead_q;
  assign Ex_Mem_Output_Select = outSel_q;
  assign Ex_Mem_opcode        = opcode_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
  import riscv_ex_pkg::*;

  localparam int XLEN    = 32;
  localparam int MD_ITER = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Ex_In_Rs1, Ex_In_Rs2, Ex_In_writereg, Wb_writereg;
  logic [31:0] Ex_In_Read_Data_1, Ex_In_Read_Data_2, Ex_In_Sign_Ex, Wb_Data;
  logic [3:0]  Ex_In_acl;
  logic [1:0]  Ex_In_Read_Data_2_Sel, Ex_In_Output_Select;
  logic        Ex_In_Reg_Write, Ex_In_MemWrite, Ex_In_MemRead, Wb_Reg_Write, Ex_Flush;
  logic [6:0]  Ex_In_opcode;
  logic        Ex_Stall;
  logic [31:0] Ex_Mem_Alu_Result, Ex_Mem_Store_Data;
  logic [4:0]  Ex_Mem_writereg;
  logic        Ex_Mem_Reg_Write, Ex_Mem_MemWrite, Ex_Mem_MemRead;
  logic [1:0]  Ex_Mem_Output_Select;
  logic [6:0]  Ex_Mem_opcode;

  ex_stage #(.XLEN(XLEN), .MD_ITER(MD_ITER)) dut (
    .clk(clk), .reset(reset),
    .Ex_In_Rs1(Ex_In_Rs1), .Ex_In_Rs2(Ex_In_Rs2),
    .Ex_In_Read_Data_1(Ex_In_Read_Data_1), .Ex_In_Read_Data_2(Ex_In_Read_Data_2),
    .Ex_In_Sign_Ex(Ex_In_Sign_Ex), .Ex_In_acl(Ex_In_acl),
    .Ex_In_Read_Data_2_Sel(Ex_In_Read_Data_2_Sel), .Ex_In_Output_Select(Ex_In_Output_Select),
    .Ex_In_writereg(Ex_In_writereg), .Ex_In_Reg_Write(Ex_In_Reg_Write),
    .Ex_In_MemWrite(Ex_In_MemWrite), .Ex_In_MemRead(Ex_In_MemRead), .Ex_In_opcode(Ex_In_opcode),
    .Wb_Reg_Write(Wb_Reg_Write), .Wb_writereg(Wb_writereg), .Wb_Data(Wb_Data),
    .Ex_Flush(Ex_Flush), .Ex_Stall(Ex_Stall),
    .Ex_Mem_Alu_Result(Ex_Mem_Alu_Result), .Ex_Mem_Store_Data(Ex_Mem_Store_Data),
    .Ex_Mem_writereg(Ex_Mem_writereg), .Ex_Mem_Reg_Write(Ex_Mem_Reg_Write),
    .Ex_Mem_MemWrite(Ex_Mem_MemWrite), .Ex_Mem_MemRead(Ex_Mem_MemRead),
    .Ex_Mem_Output_Select(Ex_Mem_Output_Select), .Ex_Mem_opcode(Ex_Mem_opcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, wreg, wbReg;
    logic [31:0] rd1, rd2, imm, wbData;
    logic [3:0]  acl;
    logic [1:0]  sel, outSel;
    logic        rw, mw, mr, wbRw;
    logic [6:0]  opcode;
  } instr_t;

  int numVectors;
  int numMiscompares;

  // Expected content of the EX/MEM register, as far as forwarding cares.
  logic        mRw, mMr;
  logic [4:0]  mWreg;
  logic [31:0] mRes;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    numVectors++;
    if (obs !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expFwd(input logic [4:0] rs, input logic [31:0] rf, input instr_t s);
    if (mRw && !mMr && mWreg != 5'd0 && mWreg == rs) return mRes;
    if (s.wbRw && s.wbReg != 5'd0 && s.wbReg == rs) return s.wbData;
    return rf;
  endfunction

  function automatic logic [31:0] pickB(input instr_t s, input logic [31:0] fb);
    if (s.sel == 2'b01) return s.imm;
    if (s.sel == 2'b10) return 32'd4;
    return fb;
  endfunction

  function automatic logic [31:0] refAlu(input logic [3:0] acl, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int signed   sa, sb;
    p  = {32'd0, a} * {32'd0, b};
    sa = a;
    sb = b;
    case (acl)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return sa >>> b[4:0];
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd12: return p[31:0];
      4'd13: return p[63:32];
      4'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd15: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic instr_t mkInstr(input logic [3:0] acl, input logic [4:0] rs1, input logic [31:0] rd1,
                                     input logic [4:0] rs2, input logic [31:0] rd2, input logic [4:0] wreg);
    instr_t s;
    s.acl = acl; s.rs1 = rs1; s.rd1 = rd1; s.rs2 = rs2; s.rd2 = rd2; s.wreg = wreg;
    s.imm = 32'd0; s.sel = 2'b00; s.outSel = 2'b01; s.opcode = 7'h33;
    s.rw = 1'b1; s.mw = 1'b0; s.mr = 1'b0;
    s.wbRw = 1'b0; s.wbReg = 5'd0; s.wbData = 32'd0;
    return s;
  endfunction

  function automatic instr_t randInstr(input bit md);
    instr_t s;
    s.rs1 = 5'($urandom_range(0, 7));  s.rs2 = 5'($urandom_range(0, 7));
    s.wreg = 5'($urandom_range(0, 7)); s.wbReg = 5'($urandom_range(0, 7));
    s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom; s.wbData = $urandom;
    s.sel = 2'($urandom_range(0, 3)); s.outSel = 2'($urandom_range(0, 3));
    s.rw = 1'($urandom_range(0, 1)); s.mw = 1'($urandom_range(0, 1));
    s.mr = 1'($urandom_range(0, 1)); s.wbRw = 1'($urandom_range(0, 1));
    s.opcode = 7'($urandom_range(0, 127));
    if (md) begin
      s.acl = 4'(12 + $urandom_range(0, 3));
      s.sel = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) s.rd2 = 32'd0;
      else if ($urandom_range(0, 1) == 1) s.rd2 = 32'($urandom_range(1, 1000));
    end else begin
      s.acl = 4'($urandom_range(0, 11));
    end
    return s;
  endfunction

  task automatic applyStimulus(input instr_t s);
    Ex_In_Rs1 = s.rs1; Ex_In_Rs2 = s.rs2;
    Ex_In_Read_Data_1 = s.rd1; Ex_In_Read_Data_2 = s.rd2; Ex_In_Sign_Ex = s.imm;
    Ex_In_acl = s.acl; Ex_In_Read_Data_2_Sel = s.sel; Ex_In_Output_Select = s.outSel;
    Ex_In_writereg = s.wreg; Ex_In_Reg_Write = s.rw; Ex_In_MemWrite = s.mw;
    Ex_In_MemRead = s.mr; Ex_In_opcode = s.opcode;
    Wb_Reg_Write = s.wbRw; Wb_writereg = s.wbReg; Wb_Data = s.wbData;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data"}, {Ex_Mem_Alu_Result, Ex_Mem_Store_Data}, 64'd0);
    checkOutput({tag, "_ctrl"}, {Ex_Mem_writereg, Ex_Mem_Reg_Write, Ex_Mem_MemWrite, Ex_Mem_MemRead,
                                 Ex_Mem_Output_Select, Ex_Mem_opcode, Ex_Stall}, 64'd0);
  endtask

  task automatic runAlu(input instr_t s, output logic [31:0] obs);
    logic [31:0] a, b, exp;
    applyStimulus(s);
    a   = expFwd(s.rs1, s.rd1, s);
    b   = expFwd(s.rs2, s.rd2, s);
    exp = refAlu(s.acl, a, pickB(s, b));
    #1 checkOutput("alu_stall", Ex_Stall, 0);
    @(posedge clk); #1;
    checkOutput("alu_result", Ex_Mem_Alu_Result, exp);
    checkOutput("alu_store", Ex_Mem_Store_Data, b);
    checkOutput("alu_ctrl", {Ex_Mem_Reg_Write, Ex_Mem_MemWrite, Ex_Mem_MemRead}, {s.rw, s.mw, s.mr});
    checkOutput("alu_pass", {Ex_Mem_writereg, Ex_Mem_Output_Select, Ex_Mem_opcode},
                {s.wreg, s.outSel, s.opcode});
    mRw = s.rw; mMr = s.mr; mWreg = s.wreg; mRes = exp;
    obs = Ex_Mem_Alu_Result;
  endtask

  // Issue a muldiv and let n edges pass; forwarding sources are scrambled to prove operands are latched.
  task automatic startMd(input instr_t s, input int n);
    applyStimulus(s);
    #1 checkOutput("md_issue_stall", Ex_Stall, 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checkOutput("md_bubble", {Ex_Mem_Reg_Write, Ex_Mem_MemWrite, Ex_Mem_MemRead}, 0);
      mRw = 1'b0;
      Wb_Reg_Write = 1'($urandom_range(0, 1)); Wb_writereg = 5'($urandom_range(0, 7)); Wb_Data = $urandom;
    end
  endtask

  task automatic runMd(input instr_t s, output logic [31:0] obs);
    logic [31:0] a, b, exp;
    int cycles;
    a   = expFwd(s.rs1, s.rd1, s);
    b   = pickB(s, expFwd(s.rs2, s.rd2, s));
    exp = refAlu(s.acl, a, b);
    startMd(s, 0);
    cycles = 0;
    while (Ex_Stall === 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      checkOutput("md_bubble", {Ex_Mem_Reg_Write, Ex_Mem_MemWrite, Ex_Mem_MemRead}, 0);
      mRw = 1'b0;
      Wb_Reg_Write = 1'($urandom_range(0, 1)); Wb_writereg = 5'($urandom_range(0, 7)); Wb_Data = $urandom;
    end
    checkOutput("md_stall_len", cycles, MD_ITER + 1);
    @(posedge clk); #1;
    checkOutput("md_result", Ex_Mem_Alu_Result, exp);
    checkOutput("md_ctrl", {Ex_Mem_Reg_Write, Ex_Mem_MemWrite, Ex_Mem_MemRead, Ex_Mem_writereg},
                {s.rw, s.mw, s.mr, s.wreg});
    mRw = s.rw; mMr = s.mr; mWreg = s.wreg; mRes = exp;
    obs = Ex_Mem_Alu_Result;
  endtask

  task automatic midReset();
    #1 reset = 1'b1;
    #1 checkAllZero("async_reset");
    mRw = 1'b0; mMr = 1'b0; mWreg = 5'd0; mRes = 32'd0;
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    instr_t s;
    logic [31:0] r;
    numVectors = 0; numMiscompares = 0;
    mRw = 1'b0; mMr = 1'b0; mWreg = 5'd0; mRes = 32'd0;
    Ex_Flush = 1'b0;
    reset = 1'b1;
    applyStimulus(mkInstr(ACL_ADD, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 checkAllZero("reset_state");
    reset = 1'b0;

    s = mkInstr(ACL_ADD, 1, 7, 2, 0, 5);          runAlu(s, r); checkOutput("x5_gets_7", r, 7);
    s = mkInstr(ACL_ADD, 5, 0, 5, 0, 6);          runAlu(s, r); checkOutput("exmem_fwd_add", r, 14);
    s = mkInstr(ACL_ADD, 1, 7, 2, 0, 0);          runAlu(s, r);
    s = mkInstr(ACL_ADD, 0, 3, 0, 4, 8);
    s.wbRw = 1'b1; s.wbReg = 5'd0; s.wbData = 32'd99; runAlu(s, r); checkOutput("x0_no_fwd", r, 7);
    s = mkInstr(ACL_ADD, 1, 9, 2, 0, 3);          runAlu(s, r);
    s = mkInstr(ACL_ADD, 3, 100, 3, 100, 9);
    s.wbRw = 1'b1; s.wbReg = 5'd3; s.wbData = 32'd2;  runAlu(s, r); checkOutput("fwd_priority", r, 18);
    checkOutput("fwd_priority_store", Ex_Mem_Store_Data, 9);
    s = mkInstr(ACL_ADD, 1, 50, 2, 0, 4); s.mr = 1'b1; runAlu(s, r);
    s = mkInstr(ACL_ADD, 4, 1, 0, 0, 10);
    s.wbRw = 1'b1; s.wbReg = 5'd4; s.wbData = 32'd2;  runAlu(s, r); checkOutput("load_not_fwd", r, 2);
    midReset();

    s = mkInstr(ACL_MUL,   10, 32'h0000_FFFF, 11, 32'h0001_0001, 12); runMd(s, r); checkOutput("mul_low", r, 32'hFFFF_FFFF);
    s = mkInstr(ACL_MULHU, 10, 32'h0000_FFFF, 11, 32'h0001_0001, 12); runMd(s, r); checkOutput("mulhu", r, 0);
    s = mkInstr(ACL_DIVU,  10, 100, 11, 7, 12);   runMd(s, r); checkOutput("divu", r, 14);
    s = mkInstr(ACL_REMU,  10, 100, 11, 7, 12);   runMd(s, r); checkOutput("remu", r, 2);
    s = mkInstr(ACL_DIVU,  10, 12345, 11, 0, 12); runMd(s, r); checkOutput("divu_by_0", r, 32'hFFFF_FFFF);
    s = mkInstr(ACL_REMU,  10, 12345, 11, 0, 12); runMd(s, r); checkOutput("remu_by_0", r, 12345);

    s = mkInstr(ACL_DIVU, 10, 1000, 11, 3, 13);
    startMd(s, 10);
    Ex_Flush = 1'b1;
    #1 checkOutput("flush_stall", Ex_Stall, 0);
    @(posedge clk); #1;
    checkOutput("flush_bubble", {Ex_Mem_Reg_Write, Ex_Mem_MemWrite, Ex_Mem_MemRead}, 0);
    Ex_Flush = 1'b0;
    mRw = 1'b0;
    s = mkInstr(ACL_ADD, 1, 20, 2, 22, 7);        runAlu(s, r); checkOutput("add_after_flush", r, 42);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) runMd(randInstr(1'b1), r);
      else runAlu(randInstr(1'b0), r);
    end

    s = randInstr(1'b1);
    startMd(s, 5);
    midReset();
    s = mkInstr(ACL_SUB, 1, 50, 2, 8, 9);         runAlu(s, r); checkOutput("sub_after_reset", r, 42);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
